// File: rtl/char_render.sv
// rtl/char_render.sv - renders one font glyph: window command, then row-by-row RGB565 pixel stream
// Pulses next_char_flag when the glyph is done so the character selector can advance.
module char_render #(
   parameter logic [15:0] Y0         = 16'd100,
   parameter logic [15:0] FG_COLOR   = 16'hFFFF,
   parameter logic [15:0] BG_COLOR   = 16'h0000,
   parameter int          SETTLE_CYC = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [8:0]  addr_start,
   input  logic [15:0] window_x0,
   input  logic [5:0]  char_length,
   input  logic [5:0]  x_size,
   output logic        next_char_flag,
   output logic [8:0]  rom_addr,
   input  logic [31:0] rom_data,
   output logic        win_valid,
   input  logic        win_ready,
   output logic [15:0] win_x0,
   output logic [15:0] win_x1,
   output logic [15:0] win_y0,
   output logic [15:0] win_y1,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [15:0] pix_data
);

   typedef enum logic [2:0] {
      IDLE, SETTLE, LATCH, WIN, RD, RWAIT, PIX, DONE
   } state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

   state_t      state;
   logic [7:0]  settle_cnt;
   logic [8:0]  base_q;
   logic [5:0]  len_q;
   logic [5:0]  xs_q;
   logic [5:0]  row;
   logic [5:0]  col;
   logic [31:0] row_word;
   logic [5:0]  row_nxt;

   assign row_nxt = row + 6'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         settle_cnt     <= '0;
         base_q         <= '0;
         len_q          <= '0;
         xs_q           <= '0;
         row            <= '0;
         col            <= '0;
         row_word       <= '0;
         next_char_flag <= 1'b0;
         rom_addr       <= '0;
         win_valid      <= 1'b0;
         win_x0         <= '0;
         win_x1         <= '0;
         win_y0         <= '0;
         win_y1         <= '0;
         pix_valid      <= 1'b0;
         pix_data       <= '0;
      end else begin
         next_char_flag <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  settle_cnt <= '0;
                  state      <= SETTLE;
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST)
                  state <= LATCH;
               else
                  settle_cnt <= settle_cnt + 8'd1;
            end
            LATCH: begin
               base_q <= addr_start;
               len_q  <= char_length;
               xs_q   <= x_size;
               win_x0 <= window_x0;
               win_x1 <= window_x0 + {10'd0, x_size};
               win_y0 <= Y0;
               win_y1 <= Y0 + {10'd0, char_length} - 16'd1;
               if (char_length == 6'd0) begin
                  next_char_flag <= 1'b1;
                  state          <= DONE;
               end else begin
                  win_valid <= 1'b1;
                  state     <= WIN;
               end
            end
            WIN: begin
               if (win_ready) begin
                  win_valid <= 1'b0;
                  row       <= '0;
                  rom_addr  <= base_q;
                  state     <= RD;
               end
            end
            // rom_addr was set on entry, so the sync ROM registers it at the end of RD
            RD: state <= RWAIT;
            RWAIT: begin
               row_word  <= rom_data << 1;
               col       <= '0;
               pix_valid <= 1'b1;
               pix_data  <= rom_data[31] ? FG_COLOR : BG_COLOR;
               state     <= PIX;
            end
            PIX: begin
               if (pix_ready) begin
                  if (col == xs_q) begin
                     pix_valid <= 1'b0;
                     if (row == len_q - 6'd1) begin
                        next_char_flag <= 1'b1;
                        state          <= DONE;
                     end else begin
                        row      <= row_nxt;
                        rom_addr <= base_q + {3'b000, row_nxt};
                        state    <= RD;
                     end
                  end else begin
                     col      <= col + 6'd1;
                     row_word <= row_word << 1;
                     pix_data <= row_word[31] ? FG_COLOR : BG_COLOR;
                  end
               end
            end
            DONE: begin
               settle_cnt <= '0;
               state      <= en ? SETTLE : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
